// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the classification helper used by both the sequencer and the stall logic.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // True for ops that open a busy window (mult/multu/div/divu).
  function automatic logic op_is_multicycle(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the {hi, lo} pair that the
// sequencer latches at the accept edge. Division by zero returns the current
// HI/LO so the later commit leaves them unchanged.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] s_prod;
  logic [63:0] u_prod;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign s_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign u_prod = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes and fix signs afterwards: truncation toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign div_signed = (op == MD_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign mag_a      = a_neg ? (~a + 32'd1) : a;
  assign mag_b      = b_neg ? (~b + 32'd1) : b;
  // A zero divisor is replaced so the divider never produces X; its result is discarded.
  assign safe_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / safe_b;
  assign ur         = mag_a % safe_b;
  assign quot       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem        = a_neg ? (~ur + 32'd1) : ur;

  // Select the result pair for the issued op.
  always_comb begin
    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    res_hi = hi;
    res_lo = lo;
    case (op)
      MD_MULT:  {res_hi, res_lo} = s_prod;
      MD_MULTU: {res_hi, res_lo} = u_prod;
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide controller for the E stage. Latches the arithmetic result
// at accept, holds a fixed-latency busy window, commits HI/LO when the window
// closes, and raises the stall request for any MD instruction waiting in D.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_md_d,
  output logic        o_busy,
  output logic        o_stall,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_accept
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state;
  logic [CW-1:0] counter;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  md_arith u_arith (
    .op     (i_op),
    .a      (i_a),
    .b      (i_b),
    .hi     (o_hi),
    .lo     (o_lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // A start while busy is dropped here; the hazard unit keeps that from happening.
  assign o_accept = i_start & ~o_busy;

  // Stall D whenever an MD window is open or is being opened this cycle.
  assign o_stall = i_md_d & (o_busy | (i_start & op_is_multicycle(i_op)));

  // FSM, busy counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      counter <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      o_hi    <= '0;
      o_lo    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (o_accept) begin
            case (i_op)
              MD_MULT, MD_MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                counter <= CW'(MULT_CYCLES);
                o_busy  <= 1'b1;
                state   <= RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                counter <= CW'(DIV_CYCLES);
                o_busy  <= 1'b1;
                state   <= RUN;
              end
              MD_MTHI: o_hi <= i_a;
              MD_MTLO: o_lo <= i_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          counter <= counter - 1'b1;
          if (counter == CW'(1)) begin
            o_hi   <= pend_hi;
            o_lo   <= pend_lo;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: multiply/divide results, busy window
// length, stall behaviour, back-to-back issue and asynchronous reset abort.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_md_d;
  logic        o_busy;
  logic        o_stall;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_accept;

  int errors = 0;
  int checks = 0;
  int n;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_md_d   (i_md_d),
    .o_busy   (o_busy),
    .o_stall  (o_stall),
    .o_hi     (o_hi),
    .o_lo     (o_lo),
    .o_accept (o_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start at a negedge, let the next posedge take it, then drop it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Count negedges at which o_busy is high; bounded so a stuck DUT still ends.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (o_busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    i_op    = MD_MULT;
    i_a     = '0;
    i_b     = '0;
    i_md_d  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_hi",   64'(o_hi),   64'd0);
    check("reset_lo",   64'(o_lo),   64'd0);

    // 1. signed / unsigned multiply of -2 and 3
    i_start = 1'b1; i_op = MD_MULT; i_a = 32'hFFFF_FFFE; i_b = 32'd3;
    #1 check("mult_accept", 64'(o_accept), 64'd1);
    check("mult_nostall", 64'(o_stall), 64'd0);
    @(negedge clk);
    i_start = 1'b0;
    count_busy(n);
    check("mult_busy_len", 64'(n), 64'd5);
    check("mult_hi", 64'(o_hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(o_lo), 64'hFFFF_FFFA);

    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    check("multu_busy_len", 64'(n), 64'd5);
    check("multu_hi", 64'(o_hi), 64'h0000_0002);
    check("multu_lo", 64'(o_lo), 64'hFFFF_FFFA);

    // 2. signed / unsigned divide
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_busy_len", 64'(n), 64'd10);
    check("div_lo", 64'(o_lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(o_hi), 64'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    count_busy(n);
    check("divu_lo", 64'(o_lo), 64'd3);
    check("divu_hi", 64'(o_hi), 64'd1);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("div_ovf_lo", 64'(o_lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(o_hi), 64'd0);

    // 3. mthi/mtlo, divide by zero, mthi when idle
    issue(MD_MTHI, 32'h11, 32'd0);
    check("mthi_nobusy", 64'(o_busy), 64'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    check("mt_hi", 64'(o_hi), 64'h11);
    check("mt_lo", 64'(o_lo), 64'h22);

    issue(MD_DIV, 32'd5, 32'd0);
    count_busy(n);
    check("div0_busy_len", 64'(n), 64'd10);
    check("div0_hi", 64'(o_hi), 64'h11);
    check("div0_lo", 64'(o_lo), 64'h22);

    issue(MD_MTHI, 32'hAB, 32'd0);
    check("mthi_hi", 64'(o_hi), 64'hAB);
    check("mthi_lo", 64'(o_lo), 64'h22);

    // 4. stall with mflo in D, and a start during busy that must be ignored
    i_md_d  = 1'b1;
    i_start = 1'b1; i_op = MD_MULT; i_a = 32'd6; i_b = 32'd7;
    #1 check("stall_issue", 64'(o_stall), 64'd1);
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        i_start = 1'b1; i_op = MD_MTLO; i_a = 32'hDEAD;
        #1 check("busy_start_ignored", 64'(o_accept), 64'd0);
      end
      if (i == 3) i_start = 1'b0;
      #1 check($sformatf("stall_busy_%0d", i), 64'({o_busy, o_stall}), 64'b11);
      @(negedge clk);
    end
    check("stall_after", 64'({o_busy, o_stall}), 64'b00);
    check("stall_lo", 64'(o_lo), 64'd42);
    check("stall_hi", 64'(o_hi), 64'd0);
    i_md_d = 1'b0;

    // 5. div held through the mult commit edge is taken the cycle after busy falls
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
    i_start = 1'b1; i_op = MD_DIV; i_a = 32'd100; i_b = 32'd7;
    count_busy(n);
    check("b2b_mult_len", 64'(n), 64'd5);
    #1 check("b2b_accept", 64'(o_accept), 64'd1);
    check("b2b_mult_hi", 64'(o_hi), 64'd1);
    check("b2b_mult_lo", 64'(o_lo), 64'd0);
    @(negedge clk);
    i_start = 1'b0;
    count_busy(n);
    check("b2b_div_len", 64'(n), 64'd10);
    check("b2b_div_lo", 64'(o_lo), 64'd14);
    check("b2b_div_hi", 64'(o_hi), 64'd2);

    // 6. async reset in busy cycle 3 of a div aborts it
    issue(MD_DIV, 32'd9, 32'd2);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_nocommit", 64'({o_busy, o_hi, o_lo}), 65'd0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    check("post_rst_len", 64'(n), 64'd5);
    check("post_rst_hi", 64'(o_hi), 64'd0);
    check("post_rst_lo", 64'(o_lo), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
